// File: rtl/i2c_target.sv
// i2c_target: SHT40-style I2C responder; ACKs DEV_ADDR, captures written bytes, serves a read frame.
// Define I2C_TARGET_CRC_GEN_EN to replace frame bytes 2 and 5 with an in-block CRC-8.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h44,
  parameter int         RD_BYTES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [47:0] meas_data,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        busy,
  output logic        master_nack
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;
  state_t state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic scl_p_q, sda_p_q, scl, sda, rise, fall, start, stop;
  logic [2:0] bit_q, bit_d, idx_q, idx_d;
  logic ack_q, ack_d, rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, cv_q, cv_d, nack_q, nack_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d, cmd_q, cmd_d, fb, rd_byte;
  logic [47:0] frame_q, frame_d;
  assign scl = scl_sync_q[1];
  assign sda = sda_sync_q[1];
  assign rise = scl & ~scl_p_q;
  assign fall = ~scl & scl_p_q;
  assign start = scl & sda_p_q & ~sda;
  assign stop = scl & ~sda_p_q & sda;
  assign sda_oe = oe_q;
  assign cmd_byte = cmd_q;
  assign cmd_valid = cv_q;
  assign busy = busy_q;
  assign master_nack = nack_q;
  assign fb = 8'(frame_q >> (6'd40 - {idx_q, 3'b000}));
`ifdef I2C_TARGET_CRC_GEN_EN
  logic [7:0] crc_t_q, crc_h_q;
  logic [4:0] crc_n_q;
  logic fb_t, fb_h, crc_go;
  assign crc_go = (state_q == ADDR_ACK) && (state_d == RD_BYTE);
  assign fb_t = crc_t_q[7] ^ frame_q[6'd47 - {1'b0, crc_n_q}];
  assign fb_h = crc_h_q[7] ^ frame_q[6'd23 - {1'b0, crc_n_q}];
  assign rd_byte = (32'(idx_q) >= RD_BYTES) ? 8'hFF : (idx_q == 3'd2) ? crc_t_q : (idx_q == 3'd5) ? crc_h_q : fb;
  // Both CRCs run MSB-first over the latched frame, finishing long before byte 2 is due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_t_q <= '0;
      crc_h_q <= '0;
      crc_n_q <= 5'd16;
    end else if (crc_go) begin
      crc_t_q <= 8'hFF;
      crc_h_q <= 8'hFF;
      crc_n_q <= '0;
    end else if (!crc_n_q[4]) begin
      crc_t_q <= {crc_t_q[6:0], 1'b0} ^ (fb_t ? 8'h31 : 8'h00);
      crc_h_q <= {crc_h_q[6:0], 1'b0} ^ (fb_h ? 8'h31 : 8'h00);
      crc_n_q <= crc_n_q + 5'd1;
    end
  end
`else
  assign rd_byte = (32'(idx_q) >= RD_BYTES) ? 8'hFF : fb;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
      state_q <= IDLE;
      bit_q <= '0;
      idx_q <= '0;
      ack_q <= 1'b0;
      rw_q <= 1'b0;
      oe_q <= 1'b0;
      busy_q <= 1'b0;
      cv_q <= 1'b0;
      nack_q <= 1'b0;
      shift_q <= '0;
      tx_q <= '0;
      cmd_q <= '0;
      frame_q <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_p_q <= scl;
      sda_p_q <= sda;
      state_q <= state_d;
      bit_q <= bit_d;
      idx_q <= idx_d;
      ack_q <= ack_d;
      rw_q <= rw_d;
      oe_q <= oe_d;
      busy_q <= busy_d;
      cv_q <= cv_d;
      nack_q <= nack_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      cmd_q <= cmd_d;
      frame_q <= frame_d;
    end
  end
  // ack_q marks the second half of a two-step phase (ACK drive, or bit 8 done / master ACK seen).
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    idx_d = idx_q;
    ack_d = ack_q;
    rw_d = rw_q;
    oe_d = oe_q;
    busy_d = busy_q;
    cv_d = 1'b0;
    nack_d = 1'b0;
    shift_d = shift_q;
    tx_d = tx_q;
    cmd_d = cmd_q;
    frame_d = frame_q;
    if (start) begin
      state_d = ADDR;
      bit_d = '0;
      ack_d = 1'b0;
      oe_d = 1'b0;
      busy_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d = 1'b0;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (rise) begin
          shift_d = {shift_q[5:0], sda};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rw_d = sda;
            ack_d = 1'b0;
            state_d = (shift_q == DEV_ADDR) ? ADDR_ACK : IGNORE;
          end
        end
        ADDR_ACK: if (fall) begin
          ack_d = ~ack_q;
          if (!ack_q) begin
            oe_d = 1'b1;
            busy_d = 1'b1;
          end else begin
            bit_d = '0;
            state_d = rw_q ? RD_BYTE : WR_BYTE;
            oe_d = rw_q & ~meas_data[47];
            if (rw_q) begin
              frame_d = meas_data;
              idx_d = '0;
              tx_d = meas_data[47:40];
            end
          end
        end
        WR_BYTE: if (rise) begin
          shift_d = {shift_q[5:0], sda};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            cmd_d = {shift_q, sda};
            cv_d = 1'b1;
            ack_d = 1'b0;
            state_d = WR_ACK;
          end
        end
        WR_ACK: if (fall) begin
          ack_d = ~ack_q;
          oe_d = ~ack_q;
          bit_d = '0;
          state_d = ack_q ? WR_BYTE : WR_ACK;
        end
        RD_BYTE: if (rise) begin
          bit_d = bit_q + 3'd1;
          ack_d = (bit_q == 3'd7);
        end else if (fall) begin
          if (ack_q) begin
            oe_d = 1'b0;
            ack_d = 1'b0;
            state_d = RD_ACK;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
            oe_d = ~tx_q[6];
          end
        end
        RD_ACK: if (rise && !ack_q) begin
          nack_d = sda;
          state_d = sda ? IGNORE : RD_ACK;
          ack_d = ~sda;
          idx_d = (sda || idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
        end else if (fall && ack_q) begin
          tx_d = rd_byte;
          oe_d = ~rd_byte[7];
          ack_d = 1'b0;
          bit_d = '0;
          state_d = RD_BYTE;
        end
        default: oe_d = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-level I2C master with a frame/command model; checks ACKs, read bytes, pulses and busy.
module tb_i2c_target;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic [47:0] meas = '0;
  logic sda_oe, cmd_valid, busy, master_nack, sda_line;
  logic [7:0] cmd_byte;
  logic [7:0] got [8];
  logic [7:0] exp_cmd [$];
  logic exp_busy = 1'b0, silent = 1'b1, prev_cv = 1'b0;
  int n_cmp = 0, n_bad = 0, exp_nack = 0, nack_cycles = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target #(.DEV_ADDR(7'h44), .RD_BYTES(6)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .meas_data(meas), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .busy(busy), .master_nack(master_nack)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c = 8'hFF;
    for (int i = 15; i >= 0; i--) c = (c[7] ^ d[i]) ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
    return c;
  endfunction

  // Byte i of the read frame as the master must see it.
  function automatic logic [7:0] exp_rd(input logic [47:0] md, input int i);
    logic [47:0] t;
    if (i >= 6) return 8'hFF;
`ifdef I2C_TARGET_CRC_GEN_EN
    if (i == 2) return crc8(md[47:32]);
    if (i == 5) return crc8(md[23:8]);
`endif
    t = md << (8 * i);
    return t[47:40];
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    wclk(4); sda_m = b; wclk(4); scl = 1'b1; wclk(4);
    #1 r = sda_line;
    chk("busy", busy, exp_busy);
    wclk(4); scl = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl = 1'b1; wclk(8); sda_m = 1'b0; wclk(8); scl = 1'b0;
    exp_busy = 1'b0; silent = 1'b1;
  endtask

  task automatic bus_rstart();
    wclk(4); sda_m = 1'b1; wclk(4); scl = 1'b1; wclk(8); sda_m = 1'b0; wclk(8); scl = 1'b0;
    exp_busy = 1'b0; silent = 1'b1;
  endtask

  task automatic bus_stop();
    wclk(4); sda_m = 1'b0; wclk(4); scl = 1'b1; wclk(8); sda_m = 1'b1; wclk(8);
    #1 exp_busy = 1'b0;
    chk("busy_after_stop", busy, exp_busy);
    silent = 1'b1;
  endtask

  task automatic wr_byte(input logic [7:0] v, input logic is_addr, input logic exp_ack);
    logic r;
    if (!is_addr && exp_ack) exp_cmd.push_back(v);
    for (int i = 7; i >= 0; i--) xfer_bit(v[i], r);
    if (is_addr) exp_busy = exp_ack;
    silent = !exp_ack;
    xfer_bit(1'b1, r);
    chk(is_addr ? "addr_ack" : "data_ack", r, !exp_ack);
  endtask

  task automatic rd_byte(input logic [7:0] exp, input logic ack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      v[i] = r;
    end
    chk("rd_byte", v, exp);
    xfer_bit(!ack, r);
    if (!ack) begin
      exp_nack++;
      silent = 1'b1;
    end
  endtask

  task automatic wr_txn(input logic [6:0] addr, input int n);
    logic m = (addr == 7'h44);
    bus_start();
    wr_byte({addr, 1'b0}, 1'b1, m);
    for (int i = 0; i < n; i++) wr_byte(8'($urandom), 1'b0, m);
    bus_stop();
  endtask

  task automatic rd_txn(input logic [47:0] md, input int n, input logic nack_last);
    logic [7:0] v;
    meas = md;
    bus_start();
    wr_byte({7'h44, 1'b1}, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      rd_byte(exp_rd(md, i), !(i == n - 1 && nack_last), v);
      got[i] = v;
    end
    bus_stop();
  endtask

  initial begin
    logic r;
    logic [7:0] v;
    logic [47:0] md;
    int n;
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (cmd_valid) begin
            chk("cmd_valid_width", prev_cv, 1'b0);
            if (exp_cmd.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL cmd_valid: got pulse with cmd_byte %0h required no pulse", cmd_byte);
            end else chk("cmd_byte", cmd_byte, exp_cmd.pop_front());
          end
          if (silent) chk("sda_released", sda_oe, 1'b0);
          if (master_nack) nack_cycles++;
        end
        prev_cv = cmd_valid;
      end
    join_none
    wclk(3);
    #1 chk("rst_sda_oe", sda_oe, 1'b0);
    rst_n = 1'b1;
    wclk(3);
    #1 chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_byte", cmd_byte, 8'h00);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_master_nack", master_nack, 1'b0);
    // Write 0xFD to 0x44.
    bus_start();
    wr_byte(8'h88, 1'b1, 1'b1);
    wr_byte(8'hFD, 1'b0, 1'b1);
    wclk(1);
    #1 chk("cmd_byte_lit", cmd_byte, 8'hFD);
    bus_stop();
    // Address 0x45 is not ours.
    wr_txn(7'h45, 1);
`ifdef I2C_TARGET_CRC_GEN_EN
    rd_txn(48'hBEEF_00_BEEF_00, 6, 1'b1);
    chk("crc_t_lit", got[2], 8'h92);
    chk("crc_h_lit", got[5], 8'h92);
`else
    rd_txn(48'h6666_9B_8000_A2, 6, 1'b1);
    chk("rd0_lit", got[0], 8'h66);
    chk("rd2_lit", got[2], 8'h9B);
    chk("rd3_lit", got[3], 8'h80);
    chk("rd5_lit", got[5], 8'hA2);
`endif
    // Repeated START mid-write, then read.
    md = {$urandom, 16'($urandom)};
    meas = md;
    bus_start();
    wr_byte(8'h88, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) xfer_bit(1'($urandom), r);
    bus_rstart();
    wr_byte(8'h89, 1'b1, 1'b1);
    rd_byte(exp_rd(md, 0), 1'b0, v);
    bus_stop();
    // 8-byte read past the frame end.
    rd_txn({$urandom, 16'($urandom)}, 8, 1'b0);
    chk("rd6_ff", got[6], 8'hFF);
    chk("rd7_ff", got[7], 8'hFF);
    // Reset while the target holds the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) xfer_bit(i == 0 ? 1'b0 : 1'(8'h88 >> i), r);
    silent = 1'b0;
    wclk(6);
    #1 chk("ack_driven", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1 chk("async_release", sda_oe, 1'b0);
    scl = 1'b1; sda_m = 1'b1;
    wclk(3);
    rst_n = 1'b1;
    exp_busy = 1'b0; silent = 1'b1;
    wclk(3);
    #1 chk("busy_after_rst", busy, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = 8'($urandom_range(0, 127));
        wr_txn($urandom_range(0, 1) == 1 ? 7'h44 : (v[6:0] == 7'h44 ? 7'h45 : v[6:0]), $urandom_range(1, 3));
      end else begin
        n = $urandom_range(1, 8);
        rd_txn({$urandom, 16'($urandom)}, n, n < 6 ? 1'b1 : 1'($urandom));
      end
    end
    wclk(10);
    chk("nack_pulses", nack_cycles, exp_nack);
    chk("cmd_outstanding", exp_cmd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
